reset_sequencer: RTL
====================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter NUM_STAGES, default 3: number of ordered reset domains driven, range 1..8.
REQ-002 Parameter HOLD_CYCLES, default 16: minimum all-asserted hold after lock, range 1..65535.
REQ-003 Parameter STAGE_DELAY, default 8: gap cycles between one stage's acknowledge and the next stage's release, range 1..65535.
REQ-004 Parameter ACK_TIMEOUT, default 1024: cycles allowed for a stage acknowledge, range 2..65535.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 reset_in  input  1  synchronous, active-high reset of this block.
REQ-007 enable  input  1  permits leaving WAIT_LOCK; ignored in every other state.
REQ-008 pll_locked  input  1  clock-source lock indication, already synchronous to clk.
REQ-009 sw_reset_req  input  1  software reset request; level sampled each cycle.
REQ-010 stage_ack  input  NUM_STAGES  per-stage "out of reset" acknowledge, already synchronous to clk.
REQ-011 reset_out  output  NUM_STAGES  per-stage reset, active-high, registered; bit 0 released first.
REQ-012 all_released  output  1  registered; high only in DONE.
REQ-013 busy  output  1  registered; high in every state except DONE.
REQ-014 timeout_err  output  1  registered sticky acknowledge-timeout flag.

Function
REQ-015 States SHALL be ASSERT, WAIT_LOCK, HOLD, RELEASE, WAIT_ACK, GAP, DONE; a 16-bit cycle counter and a stage index are shared.
REQ-016 ASSERT SHALL drive all reset_out bits high and go to WAIT_LOCK on the next edge unconditionally.
REQ-017 WAIT_LOCK SHALL remain while pll_locked=0 or enable=0, else go to HOLD with counter=0.
REQ-018 HOLD SHALL increment the counter each cycle and go to RELEASE with index=0 when counter=HOLD_CYCLES-1.
REQ-019 RELEASE SHALL clear reset_out[index] (visible after that edge) and go to WAIT_ACK with counter=0; released bits stay low until the next abort or reset.
REQ-020 WAIT_ACK with stage_ack[index]=1 SHALL go to DONE if index=NUM_STAGES-1, else to GAP with counter=0.
REQ-021 WAIT_ACK with stage_ack[index]=0 and counter=ACK_TIMEOUT-1 SHALL set timeout_err and go to ASSERT; otherwise the counter increments.
REQ-022 GAP SHALL count to STAGE_DELAY-1, then increment index and go to RELEASE.
REQ-023 DONE SHALL hold all reset_out low, all_released=1, busy=0.
REQ-024 Abort: in any state except ASSERT and WAIT_LOCK, sw_reset_req=1 or pll_locked=0 SHALL force next state ASSERT, all reset_out high on that same edge, all_released=0, busy=1.
REQ-025 In WAIT_LOCK, sw_reset_req=1 SHALL keep the FSM in WAIT_LOCK.
REQ-026 Priority SHALL be reset_in > abort > timeout > acknowledge > counter progression; a simultaneous ack and timeout at the same cycle SHALL be treated as ack.
REQ-027 stage_ack bits other than stage_ack[index] SHALL be ignored; an ack already high on entry to WAIT_ACK SHALL be accepted on the first WAIT_ACK cycle.
REQ-028 timeout_err SHALL clear only on reset_in; repeated timeouts retry the full sequence indefinitely.
REQ-029 Release latency SHALL be: reset_out[0] low after edge HOLD_CYCLES+3 (edges counted from first edge with reset_in=0, pll_locked=1, enable=1); each later stage STAGE_DELAY+2 edges after the prior stage's ack edge... measured from prior release edge when ack is immediate.

Reset
REQ-030 reset_in=1 SHALL on the same edge set state ASSERT, reset_out all ones, all_released=0, busy=1, timeout_err=0, counter=0, index=0.
REQ-031 reset_in=1 mid-sequence SHALL reassert all released stages on that edge regardless of state.

Verification (NUM_STAGES=3, HOLD_CYCLES=4, STAGE_DELAY=2, ACK_TIMEOUT=8)
REQ-032 stage_ack tied 3'b111, lock/enable high -> reset_out bit0 low after edge 7, bit1 after edge 11, bit2 after edge 15, all_released=1 after edge 16.
REQ-033 pll_locked low until edge 20 -> reset_out stays 3'b111, busy=1; bit0 low at edge 25.
REQ-034 stage_ack[1] never high -> timeout_err=1 at 8th WAIT_ACK edge for stage 1, reset_out returns to 3'b111 same edge, sequence restarts.
REQ-035 sw_reset_req pulsed one cycle in DONE -> reset_out 3'b111 on that edge, all_released=0, full re-release follows with REQ-032 timing relative to abort.
REQ-036 pll_locked drops in GAP -> immediate 3'b111, FSM to ASSERT then waits in WAIT_LOCK until relock.
REQ-037 reset_in pulsed during WAIT_ACK after a timeout -> timeout_err clears, outputs match REQ-030.

Source files
------------

// File: rtl/reset_sequencer.sv
// Ordered multi-domain reset release: hold all domains in reset until the clock
// source locks, then release them one by one, waiting for each acknowledge.
module reset_sequencer #(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_DELAY = 8,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  reset_in,
  input  logic                  enable,
  input  logic                  pll_locked,
  input  logic                  sw_reset_req,
  input  logic [NUM_STAGES-1:0] stage_ack,
  output logic [NUM_STAGES-1:0] reset_out,
  output logic                  all_released,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [15:0]   HOLD_LAST  = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0]   GAP_LAST   = 16'(STAGE_DELAY - 1);
  localparam logic [15:0]   ACK_LAST   = 16'(ACK_TIMEOUT - 1);
  localparam logic [IW-1:0] LAST_STAGE = IW'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    S_ASSERT, S_WAIT_LOCK, S_HOLD, S_RELEASE, S_WAIT_ACK, S_GAP, S_DONE
  } state_t;

  state_t          state, state_d;
  logic [15:0]     cnt, cnt_d;
  logic [IW-1:0]   idx, idx_d;
  logic            tmo_set;
  logic            abort;
  logic [NUM_STAGES-1:0] reset_out_d;
  logic            all_released_d, busy_d, timeout_err_d;

  // Abort only matters once the sequence has started counting.
  assign abort = (state != S_ASSERT) && (state != S_WAIT_LOCK) &&
                 (sw_reset_req || !pll_locked);

  always_ff @(posedge clk) begin
    if (reset_in) begin
      state        <= S_ASSERT;
      cnt          <= '0;
      idx          <= '0;
      reset_out    <= '1;
      all_released <= 1'b0;
      busy         <= 1'b1;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      idx          <= idx_d;
      reset_out    <= reset_out_d;
      all_released <= all_released_d;
      busy         <= busy_d;
      timeout_err  <= timeout_err_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    idx_d   = idx;
    tmo_set = 1'b0;
    case (state)
      S_ASSERT: begin
        state_d = S_WAIT_LOCK;
        cnt_d   = '0;
        idx_d   = '0;
      end
      S_WAIT_LOCK: begin
        if (pll_locked && enable && !sw_reset_req) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end
      end
      S_HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_d = S_RELEASE;
          idx_d   = '0;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      S_RELEASE: begin
        state_d = S_WAIT_ACK;
        cnt_d   = '0;
      end
      S_WAIT_ACK: begin
        // An ack landing on the timeout cycle still counts as an ack.
        if (stage_ack[idx]) begin
          if (idx == LAST_STAGE) begin
            state_d = S_DONE;
          end else begin
            state_d = S_GAP;
            cnt_d   = '0;
          end
        end else if (cnt == ACK_LAST) begin
          state_d = S_ASSERT;
          tmo_set = 1'b1;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          state_d = S_RELEASE;
          idx_d   = idx + 1'b1;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      S_DONE: state_d = S_DONE;
      default: state_d = S_ASSERT;
    endcase
    if (abort) begin
      state_d = S_ASSERT;
      cnt_d   = '0;
      tmo_set = 1'b0;
    end
  end

  always_comb begin
    reset_out_d = reset_out;
    if (state_d == S_ASSERT)
      reset_out_d = '1;
    else if (state == S_RELEASE)
      reset_out_d[idx] = 1'b0;
    all_released_d = (state_d == S_DONE);
    busy_d         = (state_d != S_DONE);
    timeout_err_d  = timeout_err | tmo_set;
  end

endmodule
